uart_rx: RTL and testbench

- Serial receiver for the UART; the receive-side counterpart of the existing serial transmitter.
- Oversamples the asynchronous `rx` line with the system clock, finds each frame's start bit, and samples every bit at its centre.
- Framing is runtime-selected: 7/8 data bits, optional parity, one stop bit.
- Presents the received byte plus status flags to the TramelBlaze through a ready/read handshake.

---
 rtl/uart_rx.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Finds each frame's start bit on the synchronised rx line and samples every
// bit at its centre. Framing (7/8 data bits, optional parity with selectable
// sense) and bit timing are runtime inputs, captured at the start of each frame.
// The received byte and its status flags are held for the processor until it
// acknowledges them with a single-cycle read pulse.

module uart_rx (
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] bit_period,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic        rx,
    input  logic        read,
    output logic [7:0]  rx_data,
    output logic        rx_rdy,
    output logic        perr,
    output logic        ferr,
    output logic        ovf
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Two-flop synchroniser for the asynchronous serial input
    logic        rxMeta_q;
    logic        rxSync_q;

    // Receive state machine
    state_t      state_q, state_d;

    // Set once the line has been seen high in IDLE; a start edge is honoured only when set
    logic        armed_q, armed_d;

    // Framing configuration captured on entry to START
    logic        eightCfg_q, eightCfg_d;
    logic        penCfg_q, penCfg_d;
    logic        ohelCfg_q, ohelCfg_d;
    logic [18:0] periodCfg_q, periodCfg_d;

    // Bit timer and mid-bit sample strobe
    logic [18:0] bitCnt_q, bitCnt_d;
    logic [18:0] bitTarget;
    logic        smp;

    // Data bit index, assembled data and received parity bit
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;

    // Frame completion strobe and the values it loads
    logic        frameDone;
    logic [7:0]  frameData;
    logic        frameParityErr;

    // Processor-visible result registers
    logic [7:0]  data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        ovf_q, ovf_d;

    // Synchronise rx into the clock domain; both stages reset to the idle-high level
    always_ff @(posedge clock) begin
        if (!reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // Bit timer compare: half a bit to reach the start-bit centre, a full bit thereafter
    always_comb begin
        bitTarget = periodCfg_q;
        if (state_q == START) begin
            bitTarget = {1'b0, periodCfg_q[18:1]};
        end
        smp = (state_q != IDLE) && (bitCnt_q == (bitTarget - 19'd1));
    end

    // Next-state logic for the receive FSM, timer, data capture and configuration latch
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        eightCfg_d  = eightCfg_q;
        penCfg_d    = penCfg_q;
        ohelCfg_d   = ohelCfg_q;
        periodCfg_d = periodCfg_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        frameDone   = 1'b0;

        case (state_q)
            IDLE: begin
                if (armed_q && !rxSync_q) begin
                    state_d     = START;
                    armed_d     = 1'b0;
                    eightCfg_d  = eight;
                    penCfg_d    = pen;
                    ohelCfg_d   = ohel;
                    periodCfg_d = bit_period;
                end else if (rxSync_q) begin
                    armed_d = 1'b1;
                end
            end

            START: begin
                if (smp) begin
                    if (rxSync_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        bitIdx_d = 3'd0;
                        shift_d  = 8'd0;
                    end
                end
            end

            DATA: begin
                if (smp) begin
                    shift_d[bitIdx_q] = rxSync_q;
                    if (bitIdx_q == (eightCfg_q ? 3'd7 : 3'd6)) begin
                        state_d = penCfg_q ? PARITY : STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end

            PARITY: begin
                if (smp) begin
                    parity_d = rxSync_q;
                    state_d  = STOP;
                end
            end

            STOP: begin
                if (smp) begin
                    state_d   = IDLE;
                    frameDone = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                armed_d = 1'b0;
            end
        endcase

        // The timer restarts on every strobe and every state entry and rests at zero in IDLE
        if ((state_q == IDLE) || smp || (state_d != state_q)) begin
            bitCnt_d = 19'd0;
        end else begin
            bitCnt_d = bitCnt_q + 19'd1;
        end
    end

    // Completed-frame byte and parity check; bit 7 never carries data in 7-bit mode
    always_comb begin
        frameData = shift_q;
        if (!eightCfg_q) begin
            frameData[7] = 1'b0;
        end
        frameParityErr = penCfg_q & ((^frameData ^ parity_q) != ohelCfg_q);
    end

    // Result registers: a completing frame takes priority over a read in the same cycle
    always_comb begin
        data_d = data_q;
        rdy_d  = rdy_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        ovf_d  = ovf_q;

        if (frameDone) begin
            data_d = frameData;
            rdy_d  = 1'b1;
            perr_d = frameParityErr;
            ferr_d = ~rxSync_q;
            if (read) begin
                ovf_d = 1'b0;
            end else if (rdy_q) begin
                ovf_d = 1'b1;
            end
        end else if (read) begin
            rdy_d  = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    // State, timer, capture and result registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            eightCfg_q  <= 1'b0;
            penCfg_q    <= 1'b0;
            ohelCfg_q   <= 1'b0;
            periodCfg_q <= 19'd0;
            bitCnt_q    <= 19'd0;
            bitIdx_q    <= 3'd0;
            shift_q     <= 8'd0;
            parity_q    <= 1'b0;
            data_q      <= 8'd0;
            rdy_q       <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            eightCfg_q  <= eightCfg_d;
            penCfg_q    <= penCfg_d;
            ohelCfg_q   <= ohelCfg_d;
            periodCfg_q <= periodCfg_d;
            bitCnt_q    <= bitCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            data_q      <= data_d;
            rdy_q       <= rdy_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign rx_data = data_q;
    assign rx_rdy  = rdy_q;
    assign perr    = perr_q;
    assign ferr    = ferr_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Frames are driven bit by bit on the falling clock edge; a small reference
// model of the processor-visible registers (data, rx_rdy, perr, ferr, ovf) is
// updated from the frame contents and compared against the DUT outputs.

module tb_uart_rx;

    logic        clock = 1'b0;
    logic        reset;
    logic [18:0] bit_period;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic        rx;
    logic        read;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        perr;
    logic        ferr;
    logic        ovf;

    int checks = 0;
    int passed = 0;

    // Reference model of the output registers
    logic [7:0]  mData;
    logic        mRdy;
    logic        mPerr;
    logic        mFerr;
    logic        mOvf;

    always #5 clock = ~clock;

    uart_rx dut (
        .clock      (clock),
        .reset      (reset),
        .bit_period (bit_period),
        .eight      (eight),
        .pen        (pen),
        .ohel       (ohel),
        .rx         (rx),
        .read       (read),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .perr       (perr),
        .ferr       (ferr),
        .ovf        (ovf)
    );

    // Model: clear everything
    task automatic m_clear();
        mData = 8'd0;
        mRdy  = 1'b0;
        mPerr = 1'b0;
        mFerr = 1'b0;
        mOvf  = 1'b0;
    endtask

    // Model: a frame completed with the given contents and configuration
    task automatic m_complete(input logic [7:0] d, input logic e, input logic p,
                              input logic o, input logic pb, input logic sb,
                              input logic rdSame);
        int ones;
        int nbits;
        nbits = e ? 8 : 7;
        ones  = p ? int'(pb) : 0;
        for (int i = 0; i < nbits; i++) begin
            ones += int'(d[i]);
        end
        mData = e ? d : (d & 8'h7F);
        mPerr = p && ((ones % 2) != int'(o));
        mFerr = !sb;
        if (rdSame) begin
            mOvf = 1'b0;
        end else if (mRdy) begin
            mOvf = 1'b1;
        end
        mRdy = 1'b1;
    endtask

    // Model: processor read without a coincident completion
    task automatic m_read();
        mRdy  = 1'b0;
        mPerr = 1'b0;
        mFerr = 1'b0;
        mOvf  = 1'b0;
    endtask

    task automatic set_cfg(input int per, input logic e, input logic p, input logic o);
        bit_period = 19'(per);
        eight      = e;
        pen        = p;
        ohel       = o;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    // Drive one frame; called at a falling edge, returns at a falling edge with rx high
    task automatic send_frame(input logic [7:0] d, input logic e, input logic p,
                              input logic pb, input logic sb, input int per);
        rx = 1'b0;
        repeat (per) @(negedge clock);
        for (int i = 0; i < (e ? 8 : 7); i++) begin
            rx = d[i];
            repeat (per) @(negedge clock);
        end
        if (p) begin
            rx = pb;
            repeat (per) @(negedge clock);
        end
        rx = sb;
        repeat (per) @(negedge clock);
        rx = 1'b1;
    endtask

    task automatic pulse_read();
        read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        m_read();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rx    = 1'b1;
        read  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        m_clear();
        @(negedge clock);
    endtask

    task automatic test_reset();
        set_cfg(10, 1'b1, 1'b0, 1'b0);
        do_reset();
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== 12'h000)
            $display("[TB] FAIL reset_state: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, 12'h000);
        else passed++;
    endtask

    task automatic test_latency_8n1();
        int took;
        set_cfg(10, 1'b1, 1'b0, 1'b0);
        idle(5);
        took = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 10);
            begin
                while (rx_rdy !== 1'b1 && took < 300) begin
                    @(negedge clock);
                    took++;
                end
            end
        join
        checks++;
        if (took != 98)
            $display("[TB] FAIL rdy_latency: got %0d clocks expected %0d", took, 98);
        else passed++;
        idle(4);
        m_complete(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL frame_a5: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
        pulse_read();
        checks++;
        if (rx_rdy !== 1'b0)
            $display("[TB] FAIL read_clears_rdy: got %b expected %b", rx_rdy, 1'b0);
        else passed++;
    endtask

    task automatic test_parity();
        logic [2:0] pbits = 3'b010;
        logic [2:0] senses = 3'b100;
        for (int k = 0; k < 3; k++) begin
            set_cfg(16, 1'b0, 1'b1, senses[k]);
            idle(5);
            send_frame(8'h41, 1'b0, 1'b1, pbits[k], 1'b1, 16);
            idle(6);
            m_complete(8'h41, 1'b0, 1'b1, senses[k], pbits[k], 1'b1, 1'b0);
            checks++;
            if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
                $display("[TB] FAIL parity_case%0d: got %h expected %h", k, {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
            else passed++;
            pulse_read();
        end
    endtask

    task automatic test_break();
        set_cfg(10, 1'b1, 1'b0, 1'b0);
        idle(5);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        rx = 1'b0;
        repeat (4) @(negedge clock);
        m_complete(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL framing_error: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
        pulse_read();
        repeat (500) @(negedge clock);
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL break_held: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
        idle(20);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 10);
        idle(6);
        m_complete(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL after_break: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
        pulse_read();
    endtask

    task automatic test_false_start();
        set_cfg(20, 1'b1, 1'b0, 1'b0);
        idle(5);
        rx = 1'b0;
        repeat (3) @(negedge clock);
        idle(60);
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL false_start: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 20);
        idle(6);
        m_complete(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL after_glitch: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
        pulse_read();
    endtask

    task automatic test_back_to_back();
        set_cfg(10, 1'b1, 1'b0, 1'b0);
        idle(5);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 10);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 10);
        idle(6);
        m_complete(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        m_complete(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL overflow: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
        // Second pair: read lands on the completion edge of the later frame
        // (2 sync + 5 half-bit + 9 bits of 10 clocks after the first low edge)
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 10);
        fork
            send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 10);
            begin
                repeat (97) @(negedge clock);
                read = 1'b1;
                @(negedge clock);
                read = 1'b0;
            end
        join
        idle(6);
        m_complete(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        m_complete(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL read_race: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'($urandom);
        set_cfg(12, 1'b1, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (12) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (12) @(negedge clock);
        end
        rx = d[4];
        repeat (4) @(negedge clock);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        m_clear();
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL reset_midframe: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
        idle(150);
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL reset_no_ghost: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
        d = 8'($urandom);
        send_frame(d, 1'b1, 1'b0, 1'b0, 1'b1, 12);
        idle(6);
        m_complete(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
            $display("[TB] FAIL after_reset_frame: got %h expected %h", {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
        else passed++;
        pulse_read();
    endtask

    // Random framing, data, parity and stop bits; configuration inputs are scrambled mid-frame
    task automatic test_random();
        int per;
        logic e, p, o, pb, sb;
        logic [7:0] d;
        for (int n = 0; n < 24; n++) begin
            per = $urandom_range(4, 24);
            e   = 1'($urandom);
            p   = 1'($urandom);
            o   = 1'($urandom);
            pb  = 1'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            d   = 8'($urandom);
            set_cfg(per, e, p, o);
            idle(4);
            fork
                send_frame(d, e, p, pb, sb, per);
                begin
                    repeat (per) @(negedge clock);
                    set_cfg($urandom_range(4, 40), 1'($urandom), 1'($urandom), 1'($urandom));
                end
            join
            idle(6);
            m_complete(d, e, p, o, pb, sb, 1'b0);
            checks++;
            if ({rx_data, rx_rdy, perr, ferr, ovf} !== {mData, mRdy, mPerr, mFerr, mOvf})
                $display("[TB] FAIL random_frame%0d: got %h expected %h", n, {rx_data, rx_rdy, perr, ferr, ovf}, {mData, mRdy, mPerr, mFerr, mOvf});
            else passed++;
            if ($urandom_range(0, 2) != 0) pulse_read();
        end
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        read  = 1'b0;
        set_cfg(10, 1'b1, 1'b0, 1'b0);
        m_clear();
        @(negedge clock);
        $display("[TB] starting uart_rx bench");
        test_reset();
        test_latency_8n1();
        test_parity();
        test_break();
        test_false_start();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
